// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode/execute hazard controller for the 5-stage core.
// A three-slot scoreboard (EX, MEM, WB) records in-flight destination registers.
// The controller decides each cycle whether the decode instruction may issue,
// drives the IF/ID hold, the ID/EX bubble and the whole-pipeline freeze, and
// registers operand forwarding selects for the instruction entering EX.
// Build option: define FORWARD_EN to enable operand forwarding, so that only
// load-use hazards stall. Left undefined, the block is a full interlock and
// the forwarding selects are tied to 00.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_use_s,
    input  logic        id_use_t,
    input  logic        id_wr,
    input  logic [2:0]  id_rd,
    input  logic        id_ld,
    input  logic        flush,
    input  logic        mem_busy,
    output logic        stall_fd,
    output logic        bubble_ex,
    output logic        freeze,
    output logic [1:0]  fwd_s_sel,
    output logic [1:0]  fwd_t_sel,
    output logic [15:0] stall_cnt
);

    // Scoreboard slots; a slot with wr=0 is empty.
    logic        ex_wr_q, ex_wr_d;
    logic [2:0]  ex_rd_q, ex_rd_d;
    logic        ex_ld_q, ex_ld_d;
    logic        mem_wr_q, mem_wr_d;
    logic [2:0]  mem_rd_q, mem_rd_d;
    logic        mem_ld_q, mem_ld_d;
    logic        wb_wr_q, wb_wr_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic        wb_ld_q, wb_ld_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic match_ex_s, match_ex_t, match_mem_s, match_mem_t;
    logic hazard, issue, stall;

    // The WB slot is tracked only for completeness: the register file
    // bypasses write-before-read, so WB producers never cause a hazard.
    logic unused_wb;
    assign unused_wb = ^{wb_wr_q, wb_rd_q, wb_ld_q};

    // Live source matches against the EX and MEM producers.
    always_comb begin
        match_ex_s  = id_use_s & ex_wr_q  & (ex_rd_q  == id_rs);
        match_ex_t  = id_use_t & ex_wr_q  & (ex_rd_q  == id_rt);
        match_mem_s = id_use_s & mem_wr_q & (mem_rd_q == id_rs);
        match_mem_t = id_use_t & mem_wr_q & (mem_rd_q == id_rt);
    end

`ifdef FORWARD_EN
    // With forwarding, only a load still in EX cannot supply its data in time.
    assign hazard = ex_ld_q & (match_ex_s | match_ex_t);
`else
    assign hazard = match_ex_s | match_ex_t | match_mem_s | match_mem_t;
`endif

    // Issue/stall decision; flush and mem_busy both override a hazard stall.
    always_comb begin
        issue     = id_valid & ~hazard & ~flush & ~mem_busy;
        stall     = id_valid &  hazard & ~flush & ~mem_busy;
        stall_fd  = stall;
        bubble_ex = stall;
        freeze    = mem_busy;
    end

    // Scoreboard shift and saturating stall counter next state.
    always_comb begin
        ex_wr_d     = ex_wr_q;
        ex_rd_d     = ex_rd_q;
        ex_ld_d     = ex_ld_q;
        mem_wr_d    = mem_wr_q;
        mem_rd_d    = mem_rd_q;
        mem_ld_d    = mem_ld_q;
        wb_wr_d     = wb_wr_q;
        wb_rd_d     = wb_rd_q;
        wb_ld_d     = wb_ld_q;
        stall_cnt_d = stall_cnt_q;
        if (!mem_busy) begin
            wb_wr_d  = mem_wr_q;
            wb_rd_d  = mem_rd_q;
            wb_ld_d  = mem_ld_q;
            mem_wr_d = ex_wr_q;
            mem_rd_d = ex_rd_q;
            mem_ld_d = ex_ld_q;
            if (issue) begin
                ex_wr_d = id_wr;
                ex_rd_d = id_rd;
                ex_ld_d = id_ld;
            end else begin
                ex_wr_d = 1'b0;
                ex_rd_d = 3'd0;
                ex_ld_d = 1'b0;
            end
        end
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Scoreboard and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wr_q     <= 1'b0;
            ex_rd_q     <= 3'd0;
            ex_ld_q     <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 3'd0;
            mem_ld_q    <= 1'b0;
            wb_wr_q     <= 1'b0;
            wb_rd_q     <= 3'd0;
            wb_ld_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_wr_q     <= ex_wr_d;
            ex_rd_q     <= ex_rd_d;
            ex_ld_q     <= ex_ld_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_ld_q    <= mem_ld_d;
            wb_wr_q     <= wb_wr_d;
            wb_rd_q     <= wb_rd_d;
            wb_ld_q     <= wb_ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef FORWARD_EN
    logic [1:0] fwd_s_q, fwd_s_d;
    logic [1:0] fwd_t_q, fwd_t_d;

    // Forward select for one source: nearest producer (EX) wins over MEM.
    function automatic logic [1:0] pick_sel(input logic m_ex, input logic m_mem);
        if (m_ex) begin
            return 2'b01;
        end else if (m_mem) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // Selects capture on issue, clear on a bubble, hold while frozen.
    always_comb begin
        fwd_s_d = fwd_s_q;
        fwd_t_d = fwd_t_q;
        if (!mem_busy) begin
            fwd_s_d = 2'b00;
            fwd_t_d = 2'b00;
            if (issue) begin
                fwd_s_d = pick_sel(match_ex_s, match_mem_s);
                fwd_t_d = pick_sel(match_ex_t, match_mem_t);
            end
        end
    end

    // Forwarding select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_s_q <= 2'b00;
            fwd_t_q <= 2'b00;
        end else begin
            fwd_s_q <= fwd_s_d;
            fwd_t_q <= fwd_t_d;
        end
    end

    assign fwd_s_sel = fwd_s_q;
    assign fwd_t_sel = fwd_t_q;
`else
    assign fwd_s_sel = 2'b00;
    assign fwd_t_sel = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Covers the full-interlock build
// by default and the forwarding build when FORWARD_EN is defined.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_use_s;
    logic        id_use_t;
    logic        id_wr;
    logic [2:0]  id_rd;
    logic        id_ld;
    logic        flush;
    logic        mem_busy;
    logic        stall_fd;
    logic        bubble_ex;
    logic        freeze;
    logic [1:0]  fwd_s_sel;
    logic [1:0]  fwd_t_sel;
    logic [15:0] stall_cnt;

    int total;
    int bad;

    hazard_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_s  (id_use_s),
        .id_use_t  (id_use_t),
        .id_wr     (id_wr),
        .id_rd     (id_rd),
        .id_ld     (id_ld),
        .flush     (flush),
        .mem_busy  (mem_busy),
        .stall_fd  (stall_fd),
        .bubble_ex (bubble_ex),
        .freeze    (freeze),
        .fwd_s_sel (fwd_s_sel),
        .fwd_t_sel (fwd_t_sel),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                          input logic us, input logic ut, input logic wr,
                          input logic [2:0] rd, input logic ld);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_use_s = us;
        id_use_t = ut;
        id_wr    = wr;
        id_rd    = rd;
        id_ld    = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
        tick();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        mem_busy = 1'b1;
        nop();
        #1;
        chk("rst_freeze_follows_busy", {15'd0, freeze}, 16'd1);
        mem_busy = 1'b0;
        #1;
        chk("rst_freeze_low", {15'd0, freeze}, 16'd0);
        chk("rst_stall", {15'd0, stall_fd}, 16'd0);
        chk("rst_bubble", {15'd0, bubble_ex}, 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        chk("rst_sel_s", {14'd0, fwd_s_sel}, 16'd0);
        chk("rst_sel_t", {14'd0, fwd_t_sel}, 16'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

`ifndef FORWARD_EN
        // Distance-1: ADD r1; ADD r2,r1,r1 stalls two cycles.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        #1 chk("d1_prod_stall", {15'd0, stall_fd}, 16'd0);
        tick();
        set_id(1, 3'd1, 3'd1, 1, 1, 1, 3'd2, 0);
        #1 chk("d1_stall_a", {15'd0, stall_fd}, 16'd1);
        chk("d1_bubble_a", {15'd0, bubble_ex}, 16'd1);
        tick();
        chk("d1_stall_b", {15'd0, stall_fd}, 16'd1);
        tick();
        chk("d1_stall_c", {15'd0, stall_fd}, 16'd0);
        chk("d1_cnt", stall_cnt, 16'd2);
        tick();
        chk("d1_sel_s", {14'd0, fwd_s_sel}, 16'd0);
        chk("d1_sel_t", {14'd0, fwd_t_sel}, 16'd0);
        drain();

        // Distance-2: one stall cycle.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd3, 0);
        tick();
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd4, 0);
        tick();
        set_id(1, 3'd5, 3'd3, 1, 1, 0, 3'd0, 0);
        #1 chk("d2_stall_a", {15'd0, stall_fd}, 16'd1);
        tick();
        chk("d2_stall_b", {15'd0, stall_fd}, 16'd0);
        chk("d2_cnt", stall_cnt, 16'd3);
        tick();
        drain();

        // A non-live source never matches.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd1, 3'd2, 0, 1, 0, 3'd0, 0);
        #1 chk("unused_src", {15'd0, stall_fd}, 16'd0);
        tick();
        drain();

        // r0 is an ordinary register.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd0, 0);
        tick();
        set_id(1, 3'd0, 3'd6, 1, 0, 0, 3'd0, 0);
        #1 chk("r0_stall", {15'd0, stall_fd}, 16'd1);
        tick();
        nop();
        #1 chk("r0_cnt", stall_cnt, 16'd4);
        drain();

        // Flush beats hazard; the flushed r7 writer must not enter EX.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd3, 1);
        tick();
        set_id(1, 3'd3, 3'd0, 1, 0, 1, 3'd7, 0);
        flush = 1'b1;
        #1 chk("flush_stall", {15'd0, stall_fd}, 16'd0);
        chk("flush_bubble", {15'd0, bubble_ex}, 16'd0);
        tick();
        flush = 1'b0;
        set_id(1, 3'd7, 3'd0, 1, 0, 0, 3'd0, 0);
        #1 chk("flush_ex_empty", {15'd0, stall_fd}, 16'd0);
        chk("flush_cnt", stall_cnt, 16'd4);
        tick();
        drain();

        // Freeze holds the slots; hazard resumes after release.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd1, 3'd0, 1, 0, 0, 3'd0, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_freeze", {15'd0, freeze}, 16'd1);
            chk("busy_stall", {15'd0, stall_fd}, 16'd0);
            tick();
        end
        chk("busy_cnt", stall_cnt, 16'd4);
        mem_busy = 1'b0;
        #1 chk("rel_stall_a", {15'd0, stall_fd}, 16'd1);
        chk("rel_freeze", {15'd0, freeze}, 16'd0);
        tick();
        chk("rel_stall_b", {15'd0, stall_fd}, 16'd1);
        tick();
        chk("rel_stall_c", {15'd0, stall_fd}, 16'd0);
        chk("rel_cnt", stall_cnt, 16'd6);
        tick();
        drain();

        // Reset during freeze clears slots and counter.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd1, 3'd0, 1, 0, 0, 3'd0, 0);
        mem_busy = 1'b1;
        tick();
        rst = 1'b1;
        #1 chk("rstf_cnt", stall_cnt, 16'd0);
        chk("rstf_freeze", {15'd0, freeze}, 16'd1);
        chk("rstf_stall", {15'd0, stall_fd}, 16'd0);
        mem_busy = 1'b0;
        tick();
        rst = 1'b0;
        #1 chk("rstf_slots_empty", {15'd0, stall_fd}, 16'd0);
        tick();
        chk("rstf_cnt_after", stall_cnt, 16'd0);
`else
        // ADD r1; ADD r2,r1,r4 forwards from EX/MEM without stalling.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd1, 3'd4, 1, 1, 1, 3'd2, 0);
        #1 chk("f1_stall", {15'd0, stall_fd}, 16'd0);
        tick();
        chk("f1_sel_s", {14'd0, fwd_s_sel}, 16'd1);
        chk("f1_sel_t", {14'd0, fwd_t_sel}, 16'd0);
        nop();
        tick();
        chk("f1_idle_sel_s", {14'd0, fwd_s_sel}, 16'd0);
        drain();

        // Load-use: one stall, then forward from MEM/WB.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd3, 1);
        tick();
        set_id(1, 3'd6, 3'd3, 1, 1, 1, 3'd5, 0);
        #1 chk("lu_stall_a", {15'd0, stall_fd}, 16'd1);
        chk("lu_bubble_a", {15'd0, bubble_ex}, 16'd1);
        tick();
        chk("lu_stall_b", {15'd0, stall_fd}, 16'd0);
        chk("lu_cnt", stall_cnt, 16'd1);
        tick();
        chk("lu_sel_s", {14'd0, fwd_s_sel}, 16'd0);
        chk("lu_sel_t", {14'd0, fwd_t_sel}, 16'd2);
        drain();

        // Nearest producer wins.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        tick();
        set_id(1, 3'd1, 3'd1, 1, 1, 1, 3'd2, 0);
        tick();
        chk("near_sel_s", {14'd0, fwd_s_sel}, 16'd1);
        chk("near_sel_t", {14'd0, fwd_t_sel}, 16'd1);
        drain();
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd6, 0);
        tick();
        set_id(1, 3'd1, 3'd1, 1, 1, 1, 3'd2, 0);
        tick();
        chk("gap_sel_s", {14'd0, fwd_s_sel}, 16'd2);
        chk("gap_sel_t", {14'd0, fwd_t_sel}, 16'd2);
        drain();

        // Flush beats load-use; flushed r7 writer leaves EX empty.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd3, 1);
        tick();
        set_id(1, 3'd3, 3'd0, 1, 0, 1, 3'd7, 0);
        flush = 1'b1;
        #1 chk("flush_stall", {15'd0, stall_fd}, 16'd0);
        tick();
        flush = 1'b0;
        set_id(1, 3'd7, 3'd0, 1, 0, 0, 3'd0, 0);
        #1 chk("flush_cnt", stall_cnt, 16'd1);
        tick();
        chk("flush_ex_empty", {14'd0, fwd_s_sel}, 16'd0);
        drain();

        // Load-use under freeze: selects hold, one stall after release.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd1, 3'd0, 1, 0, 1, 3'd3, 1);
        tick();
        set_id(1, 3'd3, 3'd3, 1, 1, 0, 3'd0, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_freeze", {15'd0, freeze}, 16'd1);
            chk("busy_stall", {15'd0, stall_fd}, 16'd0);
            tick();
            chk("busy_sel_hold", {14'd0, fwd_s_sel}, 16'd1);
        end
        chk("busy_cnt", stall_cnt, 16'd1);
        mem_busy = 1'b0;
        #1 chk("rel_stall_a", {15'd0, stall_fd}, 16'd1);
        tick();
        chk("rel_stall_b", {15'd0, stall_fd}, 16'd0);
        chk("rel_cnt", stall_cnt, 16'd2);
        tick();
        chk("rel_sel_s", {14'd0, fwd_s_sel}, 16'd2);
        chk("rel_sel_t", {14'd0, fwd_t_sel}, 16'd2);
        drain();

        // Reset during freeze clears selects and counter.
        set_id(1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        tick();
        set_id(1, 3'd1, 3'd0, 1, 0, 1, 3'd3, 1);
        tick();
        set_id(1, 3'd3, 3'd0, 1, 0, 0, 3'd0, 0);
        mem_busy = 1'b1;
        tick();
        rst = 1'b1;
        #1 chk("rstf_sel_s", {14'd0, fwd_s_sel}, 16'd0);
        chk("rstf_cnt", stall_cnt, 16'd0);
        chk("rstf_stall", {15'd0, stall_fd}, 16'd0);
        chk("rstf_freeze", {15'd0, freeze}, 16'd1);
        mem_busy = 1'b0;
        tick();
        rst = 1'b0;
        #1 chk("rstf_slots_empty", {15'd0, stall_fd}, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
